// File: rtl/aes128_encrypt_ctrl.sv
// Iterative AES-128 encryptor: initial AddRoundKey, rounds 1..9 one per clock, then final round; out_valid 10 clocks after accept.
// Backpressure: ciphertext/out_valid hold until out_ready; in_ready is low while a block is in flight (one block at a time).
module aes128_encrypt_ctrl #(
  parameter int NR     = 10,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] plaintext,
  input  logic [DATA_W-1:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ciphertext,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused; byte index is 4*column+row, byte 0 in the top bits
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One key-schedule step: previous round key in, next round key out
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e              fsm_q, fsm_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] state_reg_q, state_reg_d;
  logic [DATA_W-1:0] key_reg_q, key_reg_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic              ovld_q, ovld_d;

  logic [3:0]        round;
  logic [3:0]        rc_sel;
  logic [127:0]      sr, key_rnd, out_data;

  // Round-iteration datapath; the key schedule is shared between ROUND and FINAL
  always_comb begin
    round    = (fsm_q == ROUND) ? cnt_q : 4'd0;
    rc_sel   = (fsm_q == FINAL) ? cnt_q : round;
    sr       = sub_shift(state_reg_q);
    key_rnd  = next_key(key_reg_q, rcon(rc_sel));
    out_data = mix_columns(sr) ^ key_rnd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      cnt_q       <= 4'd0;
      state_reg_q <= '0;
      key_reg_q   <= '0;
      ct_q        <= '0;
      ovld_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_reg_q <= state_reg_d;
      key_reg_q   <= key_reg_d;
      ct_q        <= ct_d;
      ovld_q      <= ovld_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    state_reg_d = state_reg_q;
    key_reg_d   = key_reg_q;
    ct_d        = ct_q;
    ovld_d      = ovld_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_reg_d = plaintext ^ key;
          key_reg_d   = key;
          cnt_d       = 4'd1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        state_reg_d = out_data;
        key_reg_d   = key_rnd;
        cnt_d       = cnt_q + 4'd1;
        if (cnt_q == 4'(NR - 1)) fsm_d = FINAL;
      end
      FINAL: begin
        ct_d   = sr ^ key_rnd;
        ovld_d = 1'b1;
        fsm_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ovld_d = 1'b0;
          cnt_d  = 4'd0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign in_ready   = (fsm_q == IDLE) && !rst;
  assign busy       = (fsm_q != IDLE);
  assign out_valid  = ovld_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes128_encrypt_ctrl.sv
// Bench for aes128_encrypt_ctrl: byte-matrix AES reference with a derived S-box, cycle-level handshake model.
module tb_aes128_encrypt_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] plaintext = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext;
  logic         busy;

  aes128_encrypt_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R21 = 128'ha49c7ff2689f352b6b5bea43026a5049;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] sb [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box derived from the GF(2^8) inverse and affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Reference AES-128 with full key schedule; nr < 10 returns the state after that round
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = t[r][(c+r)%4];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r][c];
          s[0][c] = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
          s[1][c] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
          s[2][c] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
          s[3][c] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
        end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  // Transaction-level model: clocks since accept, pending result, output handshake
  logic         m_busy = 1'b0;
  logic         m_ovld = 1'b0;
  int           m_cnt  = 0;
  logic [127:0] m_exp  = '0;
  logic [127:0] m_ct   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_ovld = 1'b0;
      m_cnt  = 0;
      m_ct   = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_exp  = aes_ref(plaintext, key, 10);
      end
    end else if (m_ovld) begin
      if (out_ready) begin
        m_ovld = 1'b0;
        m_busy = 1'b0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 10) begin
        m_ovld = 1'b1;
        m_ct   = m_exp;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 128'(in_ready), 128'(!rst && !m_busy));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("out_valid", 128'(out_valid), 128'(m_ovld));
    chk("ciphertext", ciphertext, m_ct);
  end

  task automatic send(input logic [127:0] p, input logic [127:0] k, output int acc_cyc);
    bit done = 0;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    acc_cyc   = -1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        done     = 1;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      chk("accept_timeout", 128'(0), 128'(1));
    end
  endtask

  task automatic wait_out(output int lat);
    bit done = 0;
    lat = -1;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat  = i;
        done = 1;
      end
    end
    if (!done) chk("out_valid_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat, a1, a2;
    bit stable;
    build_sbox();
    chk("model_c1", aes_ref(P1, K1, 10), C1);
    chk("model_b_round1", aes_ref(P2, K2, 1), R21);
    chk("model_b", aes_ref(P2, K2, 10), C2);

    rst = 1'b1;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ciphertext", ciphertext, 128'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // C.1 vector, latency, then 20 clocks of backpressure
    send(P1, K1, a1);
    wait_out(lat);
    chk("v1_latency", 128'(lat), 128'(10));
    chk("v1_ct", ciphertext, C1);
    stable = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (ciphertext !== C1 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
    end
    chk("backpressure_stable", 128'(stable), 128'(1));
    drain();
    chk("post_hs_out_valid", 128'(out_valid), 128'(0));
    chk("post_hs_ct_held", ciphertext, C1);

    // Appendix B vector with round-1 intermediate
    send(P2, K2, a1);
    @(posedge clk);
    #1 chk("v2_round1_state", dut.state_reg_q, R21);
    wait_out(lat);
    chk("v2_latency", 128'(lat), 128'(9));
    chk("v2_ct", ciphertext, C2);
    drain();

    // in_valid with all-ones data while busy must be ignored
    send(P1, K1, a1);
    repeat (3) @(posedge clk);
    #1;
    plaintext = '1;
    key       = '1;
    in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(lat);
    chk("busy_ignore_ct", ciphertext, C1);
    drain();

    // Abort at round_cnt=5, then re-accept on the first low cycle
    send(P1, K1, a1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("abort_release_in_ready", 128'(in_ready), 128'(1));
    send(P2, K2, a1);
    wait_out(lat);
    chk("post_abort_latency", 128'(lat), 128'(10));
    chk("post_abort_ct", ciphertext, C2);
    drain();

    // Back-to-back with in_valid held and out_ready high
    out_ready = 1'b1;
    send(P1, K1, a1);
    send(P2, K2, a2);
    chk("b2b_spacing", 128'(a2 - a1), 128'(12));
    chk("b2b_first_ct", ciphertext, C1);
    wait_out(lat);
    chk("b2b_second_ct", ciphertext, C2);
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 399) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
